seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Serial pattern transmitter. It emits a programmable PAT_W-bit pattern one bit per clock, repeated N times, with an idle gap between repetitions.
- Produces stimulus and link traffic for the team's serial sequence detectors; sits between a control/CSR master and a single-bit serial line.
- Request side uses a valid/ready handshake. Completion is a one-cycle done pulse.

Parameters:
- PAT_W, 4, pattern width in bits (>=1).
- CNT_W, 8, width of the repetition count.
- GAP_CYC, 2, idle cycles between repetitions (0 = back-to-back).
- MSB_FIRST, 1, 1 = pattern[PAT_W-1] sent first; 0 = pattern[0] sent first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_pattern  in  PAT_W  pattern to send.
- req_count  in  CNT_W  number of repetitions.
- abort  in  1  synchronous cancel.
- tx_bit  out  1  serial data.
- tx_valid  out  1  tx_bit is a live pattern bit.
- busy  out  1  transfer in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: synchronous, active-high. Every output is registered and reset to 0, except req_ready, which is 1 after reset. State returns to IDLE. rst during any state aborts the transfer with no done pulse.
- Handshake:
  - Accept occurs on a clock edge where req_valid && req_ready.
  - req_ready = (state==IDLE) && !abort.
  - req_pattern and req_count are latched at accept. Later changes to those inputs are ignored.
  - req_valid while busy is ignored; it is not queued.
- States: IDLE, SHIFT, GAP, DONE (enum).
- IDLE -> SHIFT on accept with req_count != 0. Load the bit index to 0 and the remaining-repetition count to req_count.
- IDLE -> DONE on accept with req_count == 0. No bits are sent.
- SHIFT:
  - tx_valid = 1. tx_bit = pattern[PAT_W-1-idx] when MSB_FIRST, else pattern[idx]. idx increments each cycle.
  - On the last bit, decrement reps.
  - If reps remain: go to GAP when GAP_CYC > 0, else stay in SHIFT with idx = 0.
  - If no reps remain: go to DONE.
- GAP: tx_valid = 0, tx_bit = 0, lasts exactly GAP_CYC cycles, then SHIFT with idx = 0.
- DONE: done = 1 for exactly one cycle, req_ready = 0, then IDLE.
- Latency:
  - First bit is visible the cycle after the accept edge.
  - done is asserted the cycle after the last bit.
  - Total cycles from accept to done = N*PAT_W + (N-1)*GAP_CYC + 1 for N >= 1.
- abort:
  - In SHIFT, GAP or DONE: next state is IDLE, tx_valid and done are 0 from the next cycle, and no done pulse is generated.
  - abort and req_valid together in IDLE: abort wins and no accept occurs.
- Counter widths:
  - idx is $clog2(PAT_W+1) bits.
  - reps is CNT_W bits, so the maximum is 2^CNT_W-1 repetitions.
  - No counter ever wraps; all terminal compares are equality tests.

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- Defined: after the last pattern bit of each repetition, one extra SHIFT-phase bit is sent with tx_valid = 1. Its value is the even-parity bit (XOR of the latched pattern). Each repetition becomes PAT_W+1 bits and the latency formula uses PAT_W+1.
- Undefined: no parity bit and no parity logic.

Decomposition:
- Package seq_tx_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, SHIFT, GAP, DONE};
  - localparam functions for the idx width and the gap-counter width.
- One sub-module, seq_tx_shreg: a loadable PAT_W-bit shift register with direction set by MSB_FIRST and a serial output. The FSM, counters and handshake stay in the top level.

Test Plan:
- Single repetition: pattern 4'b1011, count 1, GAP_CYC 2 -> tx_bit 1,0,1,1 on 4 consecutive cycles with tx_valid = 1 starting the cycle after accept; done in cycle 5; req_ready = 1 again in cycle 6.
- Repetitions with gap: pattern 4'b1011, count 3, GAP_CYC 2 -> 1011,gap,gap,1011,gap,gap,1011; gap cycles have tx_valid = 0; done exactly 17 cycles after accept.
- Zero count: req_count 0 -> tx_valid never asserts, done pulses the cycle after accept, busy high for 1 cycle.
- Abort and reset mid-transfer: abort in the 2nd bit of repetition 2 -> IDLE next cycle, no done, req_ready = 1. Repeat with rst instead of abort -> all outputs 0 and state IDLE.
- Request while busy: req_valid held high with a new pattern 4'b0110 during a transfer -> ignored; the original pattern completes; the new request is accepted only in IDLE.
- Parity (SEQ_PATTERN_TX_PARITY_EN defined): pattern 4'b1011, count 1 -> bits 1,0,1,1,1 with tx_valid = 1 for 5 cycles, done in cycle 6. Pattern 4'b0110 -> parity bit 0.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared types and width helpers for the serial pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} tx_state_t;

  // Bit-index counter must be able to hold PAT_W (parity slot)
  function automatic int idx_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int gap_w(input int gap_cyc);
    return (gap_cyc > 1) ? $clog2(gap_cyc) : 1;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable PAT_W-bit shift register; shifts toward the serial head every cycle
// it is not loaded, filling with zeros.
module seq_tx_shreg #(
  parameter int PAT_W     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [PAT_W-1:0] i_data,
  output logic             o_ser
);

  logic [PAT_W-1:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_sr <= '0;
    else if (i_load)
      r_sr <= i_data;
    else if (MSB_FIRST != 0)
      r_sr <= r_sr << 1;
    else
      r_sr <= r_sr >> 1;
  end

  assign o_ser = (MSB_FIRST != 0) ? r_sr[PAT_W-1] : r_sr[0];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: PAT_W-bit pattern sent N times with GAP_CYC idle gaps.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to each repetition.
//
// state | meaning
// IDLE  | waiting for a request
// SHIFT | a pattern (or parity) bit is on tx_bit
// GAP   | idle line between repetitions
// DONE  | one-cycle completion pulse
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W     = 4,
  parameter int CNT_W     = 8,
  parameter int GAP_CYC   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PAT_W-1:0] req_pattern,
  input  logic [CNT_W-1:0] req_count,
  input  logic             abort,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W    = idx_w(PAT_W);
  localparam int GAP_W    = gap_w(GAP_CYC);
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int LAST     = PAT_W;
  localparam int HEAD     = (MSB_FIRST != 0) ? PAT_W - 1 : 0;
`else
  localparam int LAST     = PAT_W - 1;
`endif

  tx_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_reps;
  logic [GAP_W-1:0] r_gap;
  logic [PAT_W-1:0] r_pattern;
  logic             r_idle, r_tx_valid, r_busy, r_done;
  logic             w_accept, w_last_bit, w_more_reps, w_rep_start;
  logic             w_sr_load, w_sr_ser;
  logic [PAT_W-1:0] w_sr_data;

  assign req_ready   = r_idle && !abort;
  assign w_accept    = req_valid && req_ready;
  assign w_last_bit  = (r_idx == IDX_W'(LAST));
  assign w_more_reps = (r_reps != CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = (req_count == '0) ? DONE : SHIFT;
      SHIFT: begin
        if (abort)                 w_state_nxt = IDLE;
        else if (w_last_bit) begin
          if (!w_more_reps)        w_state_nxt = DONE;
          else if (GAP_CYC > 0)    w_state_nxt = GAP;
          else                     w_state_nxt = SHIFT;
        end
      end
      GAP: begin
        if (abort)                 w_state_nxt = IDLE;
        else if (r_gap == '0)      w_state_nxt = SHIFT;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic [PAT_W-1:0] w_par_word;
  always_comb begin
    w_par_word       = '0;
    w_par_word[HEAD] = ^r_pattern;
  end
`endif

  // Loading zeros whenever no bit follows keeps tx_bit low outside SHIFT
  assign w_rep_start = (w_state_nxt == SHIFT) && ((r_state != SHIFT) || w_last_bit);
  always_comb begin
    w_sr_load = 1'b1;
    w_sr_data = '0;
    if (w_rep_start)
      w_sr_data = (r_state == IDLE) ? req_pattern : r_pattern;
    else if ((r_state == SHIFT) && (w_state_nxt == SHIFT)) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
      if (r_idx == IDX_W'(PAT_W - 1))
        w_sr_data = w_par_word;
      else
        w_sr_load = 1'b0;
`else
      w_sr_load = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_reps     <= '0;
      r_gap      <= GAP_W'(GAP_LAST);
      r_pattern  <= '0;
      r_idle     <= 1'b1;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle     <= (w_state_nxt == IDLE);
      r_tx_valid <= (w_state_nxt == SHIFT);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_pattern <= req_pattern;
        r_reps    <= req_count;
      end else if ((r_state == SHIFT) && w_last_bit)
        r_reps <= r_reps - CNT_W'(1);
      if ((r_state == SHIFT) && (w_state_nxt == SHIFT) && !w_last_bit)
        r_idx <= r_idx + IDX_W'(1);
      else
        r_idx <= '0;
      // Gap timer: down-counter reloaded whenever outside GAP
      if (r_state != GAP)
        r_gap <= GAP_W'(GAP_LAST);
      else if (r_gap != '0)
        r_gap <= r_gap - GAP_W'(1);
    end
  end

  seq_tx_shreg #(
    .PAT_W    (PAT_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .i_clk (clk),
    .i_rst (rst),
    .i_load(w_sr_load),
    .i_data(w_sr_data),
    .o_ser (w_sr_ser)
  );

  assign tx_bit   = w_sr_ser;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a per-cycle expected-stream model.
module tb_seq_pattern_tx;

  localparam int PAT_W     = 4;
  localparam int CNT_W     = 8;
  localparam int GAP_CYC   = 2;
  localparam int MSB_FIRST = 1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst, req_valid, req_ready, abort;
  logic             tx_bit, tx_valid, busy, done;
  logic [PAT_W-1:0] req_pattern;
  logic [CNT_W-1:0] req_count;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic ev[$];
  logic eb[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC), .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pattern(req_pattern), .req_count(req_count), .abort(abort),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  task automatic chk_eq(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic b,
                            input logic bz, input logic d, input logic rdy);
    chk_eq({tag, ".tx_valid"},  tx_valid,  v);
    chk_eq({tag, ".tx_bit"},    tx_bit,    b);
    chk_eq({tag, ".busy"},      busy,      bz);
    chk_eq({tag, ".done"},      done,      d);
    chk_eq({tag, ".req_ready"}, req_ready, rdy);
  endtask

  // Line contents for each cycle after accept, up to (not including) done
  task automatic build_model(input logic [PAT_W-1:0] pat, input int cnt);
    ev.delete();
    eb.delete();
    for (int r = 0; r < cnt; r++) begin
      for (int k = 0; k < PAT_W + PAR; k++) begin
        ev.push_back(1'b1);
        if (k == PAT_W)          eb.push_back(^pat);
        else if (MSB_FIRST != 0) eb.push_back(pat[PAT_W-1-k]);
        else                     eb.push_back(pat[k]);
      end
      if (r < cnt - 1)
        for (int g = 0; g < GAP_CYC; g++) begin
          ev.push_back(1'b0);
          eb.push_back(1'b0);
        end
    end
  endtask

  // Returns just after the accept edge (cycle 1)
  task automatic request(input logic [PAT_W-1:0] pat, input int cnt);
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_pattern = pat;
    req_count   = CNT_W'(cnt);
    @(negedge clk);
    chk_eq("ready_pre", req_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [PAT_W-1:0] pat, input int cnt,
                         input bit noise, input logic [PAT_W-1:0] npat);
    int len;
    build_model(pat, cnt);
    len = ev.size() + 1;
    request(pat, cnt);
    if (noise) begin
      req_pattern = npat;
      req_count   = CNT_W'($urandom_range(1, 3));
    end else
      req_valid = 1'b0;
    for (int i = 1; i <= len; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (i < len) expect_out("bit", ev[i-1], eb[i-1], 1'b1, 1'b0, 1'b0);
      else         expect_out("done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    expect_out("post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_abort(input logic [PAT_W-1:0] pat, input int cnt,
                           input int acyc_in, input bit use_rst);
    int acyc;
    build_model(pat, cnt);
    acyc = (acyc_in == 0) ? int'($urandom_range(1, ev.size())) : acyc_in;
    request(pat, cnt);
    req_valid = 1'b0;
    for (int i = 1; i <= acyc; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (i == acyc) begin
        if (use_rst) rst = 1'b1;
        else         abort = 1'b1;
      end
      @(negedge clk);
      expect_out("pre_abort", ev[i-1], eb[i-1], 1'b1, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    rst   = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    expect_out("aborted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk_eq("no_done", done, 1'b0);
      chk_eq("quiet_valid", tx_valid, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_pattern = '0;
    req_count   = '0;
    abort       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    run_txn(4'b1011, 1, 1'b0, 4'b0000);
    run_txn(4'b1011, 3, 1'b0, 4'b0000);
    run_txn(4'b1011, 0, 1'b0, 4'b0000);
    run_txn(4'b1011, 2, 1'b1, 4'b0110);
    run_txn(4'b0110, 1, 1'b0, 4'b0000);
    run_abort(4'b1011, 3, 8, 1'b0);
    run_abort(4'b1011, 3, 8, 1'b1);

    // abort beats a simultaneous request in IDLE
    @(posedge clk); #1;
    req_valid   = 1'b1;
    req_pattern = 4'b1111;
    req_count   = CNT_W'(1);
    abort       = 1'b1;
    @(negedge clk);
    chk_eq("abort_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    chk_eq("abort_noaccept.busy", busy, 1'b0);
    chk_eq("abort_noaccept.tx_valid", tx_valid, 1'b0);

    repeat (30)
      run_txn(PAT_W'($urandom), int'($urandom_range(0, 4)),
              bit'($urandom_range(0, 1)), PAT_W'($urandom));
    repeat (8)
      run_abort(PAT_W'($urandom), int'($urandom_range(1, 4)), 0,
                bit'($urandom_range(0, 1)));
    run_txn(PAT_W'($urandom), (1 << CNT_W) - 1, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
